alu_md: RTL and testbench



---
 rtl/alu_md_pkg.sv | 40 ++++
 rtl/alu_md_if.sv | 33 +++
 rtl/alu_md_engine.sv | 171 +++++++++++++++++
 rtl/alu_md.sv | 77 +++++++
 tb/tb_alu_md.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_md_pkg.sv
// Shared types for the execute-stage ALU and the multiply/divide engine.
// Opcode enums, engine state enum and the iteration counter width.
package alu_md_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_OR   = 3'd2,
      ALU_SLT  = 3'd3,
      ALU_AND  = 3'd4,
      ALU_XOR  = 3'd5,
      ALU_SLTU = 3'd6,
      ALU_NOR  = 3'd7
   } alu_op_e;

   // Code 7 is unused and behaves like MD_NONE.
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   localparam int W_DEFAULT     = 32;
   localparam int CNT_W_DEFAULT = $clog2(W_DEFAULT);

   function automatic int cnt_width(input int w);
      return $clog2(w);
   endfunction

endpackage

// File: rtl/alu_md_if.sv
// Execute-stage bundle: ALU operands/results plus the MD request, HI/LO and engine state.
// valid/ready: md_start is a one-cycle request accepted only while busy is low; busy low means HI/LO are current.
interface alu_md_if
   import alu_md_pkg::*;
#(
   parameter int W = 32
) ();

   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [2:0]   alu_op;
   logic         ovf_en;
   logic [W-1:0] alu_res;
   logic         zero;
   logic         overflow;
   logic         md_start;
   logic [2:0]   md_op;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   md_state_e    md_state;

   modport master (
      output a, b, alu_op, ovf_en, md_start, md_op,
      input  alu_res, zero, overflow, busy, hi, lo, md_state
   );

   modport slave (
      input  a, b, md_start, md_op,
      output busy, hi, lo, md_state
   );

endinterface

// File: rtl/alu_md_engine.sv
// Iterative multiply/divide engine owning HI/LO: shift-add multiply, restoring divide.
// Divider datapath is present only when ALU_MD_DIV_EN is defined.
module md_engine
   import alu_md_pkg::*;
#(
   parameter int W = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_md_if.slave  bus
);

   localparam int CW = cnt_width(W);

   md_state_e      state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           is_mul_q, is_mul_d;
   logic           neg_q, neg_d;
   logic [W-1:0]   acc_q, acc_d;
   logic [W-1:0]   mreg_q, mreg_d;
   logic [W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;

   logic           signed_op;
   logic [W-1:0]   abs_a, abs_b;
   logic [W:0]     mul_sum;
   logic [2*W-1:0] prod_raw, prod_fix;

`ifdef ALU_MD_DIV_EN
   logic           rneg_q, rneg_d;
   logic           divz_q, divz_d;
   logic [W:0]     div_shift, div_diff;
`endif

   assign abs_a = bus.a[W-1] ? -bus.a : bus.a;
   assign abs_b = bus.b[W-1] ? -bus.b : bus.b;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_mul_d  = is_mul_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      mreg_d    = mreg_q;
      mcand_d   = mcand_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      signed_op = 1'b0;
`ifdef ALU_MD_DIV_EN
      rneg_d    = rneg_q;
      divz_d    = divz_q;
      div_shift = {acc_q, mreg_q[W-1]};
      div_diff  = div_shift - {1'b0, mcand_q};
`endif
      mul_sum  = {1'b0, acc_q} + ({1'b0, mcand_q} & {(W+1){mreg_q[0]}});
      prod_raw = {acc_q, mreg_q};
      prod_fix = neg_q ? -prod_raw : prod_raw;

      case (state_q)
         ST_IDLE: begin
            if (bus.md_start) begin
               case (bus.md_op)
                  MD_MULT, MD_MULTU: begin
                     signed_op = (bus.md_op == MD_MULT);
                     state_d   = ST_RUN;
                     cnt_d     = '0;
                     is_mul_d  = 1'b1;
                     acc_d     = '0;
                     mcand_d   = signed_op ? abs_a : bus.a;
                     mreg_d    = signed_op ? abs_b : bus.b;
                     neg_d     = signed_op & (bus.a[W-1] ^ bus.b[W-1]);
                  end
`ifdef ALU_MD_DIV_EN
                  // Dividend shifts out of mreg while quotient bits shift in behind it.
                  MD_DIV, MD_DIVU: begin
                     signed_op = (bus.md_op == MD_DIV);
                     state_d   = ST_RUN;
                     cnt_d     = '0;
                     is_mul_d  = 1'b0;
                     acc_d     = '0;
                     mreg_d    = signed_op ? abs_a : bus.a;
                     mcand_d   = signed_op ? abs_b : bus.b;
                     neg_d     = signed_op & (bus.a[W-1] ^ bus.b[W-1]);
                     rneg_d    = signed_op & bus.a[W-1];
                     divz_d    = (bus.b == '0);
                  end
`endif
                  MD_MTHI: hi_d = bus.a;
                  MD_MTLO: lo_d = bus.a;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (is_mul_q) begin
               acc_d  = mul_sum[W:1];
               mreg_d = {mul_sum[0], mreg_q[W-1:1]};
            end
`ifdef ALU_MD_DIV_EN
            else begin
               if (!div_diff[W]) begin
                  acc_d  = div_diff[W-1:0];
                  mreg_d = {mreg_q[W-2:0], 1'b1};
               end else begin
                  acc_d  = div_shift[W-1:0];
                  mreg_d = {mreg_q[W-2:0], 1'b0};
               end
            end
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (is_mul_q) begin
               {hi_d, lo_d} = prod_fix;
            end
`ifdef ALU_MD_DIV_EN
            else begin
               lo_d = divz_q ? '1 : (neg_q ? -mreg_q : mreg_q);
               hi_d = rneg_q ? -acc_q : acc_q;
            end
`endif
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset aborts any iteration outright; HI/LO never see a partial result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         mreg_q   <= '0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef ALU_MD_DIV_EN
         rneg_q   <= 1'b0;
         divz_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_mul_q <= is_mul_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mreg_q   <= mreg_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef ALU_MD_DIV_EN
         rneg_q   <= rneg_d;
         divz_q   <= divz_d;
`endif
      end
   end

   assign bus.busy     = (state_q != ST_IDLE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign bus.md_state = state_q;

endmodule

// File: rtl/alu_md.sv
// Execute-stage arithmetic: combinational MIPS ALU plus the iterative HI/LO engine.
// Define ALU_MD_DIV_EN to build DIV/DIVU support into the engine.
module alu_md
   import alu_md_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   alu_op,
   input  logic         ovf_en,
   output logic [W-1:0] alu_res,
   output logic         zero,
   output logic         overflow,
   input  logic         md_start,
   input  logic [2:0]   md_op,
   output logic         busy,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo
);

   alu_md_if #(.W(W)) md_bus ();

   logic [W-1:0] sum, diff, res_c;
   logic         ovf_c;

   assign md_bus.a        = a;
   assign md_bus.b        = b;
   assign md_bus.alu_op   = alu_op;
   assign md_bus.ovf_en   = ovf_en;
   assign md_bus.md_start = md_start;
   assign md_bus.md_op    = md_op;

   always_comb begin
      sum   = md_bus.a + md_bus.b;
      diff  = md_bus.a - md_bus.b;
      res_c = '0;
      ovf_c = 1'b0;
      case (md_bus.alu_op)
         ALU_ADD: begin
            res_c = sum;
            ovf_c = (md_bus.a[W-1] == md_bus.b[W-1]) && (sum[W-1] != md_bus.a[W-1]);
         end
         ALU_SUB: begin
            res_c = diff;
            ovf_c = (md_bus.a[W-1] != md_bus.b[W-1]) && (diff[W-1] != md_bus.a[W-1]);
         end
         ALU_OR:   res_c = md_bus.a | md_bus.b;
         ALU_SLT:  res_c = {{(W-1){1'b0}}, $signed(md_bus.a) < $signed(md_bus.b)};
         ALU_AND:  res_c = md_bus.a & md_bus.b;
         ALU_XOR:  res_c = md_bus.a ^ md_bus.b;
         ALU_SLTU: res_c = {{(W-1){1'b0}}, md_bus.a < md_bus.b};
         ALU_NOR:  res_c = ~(md_bus.a | md_bus.b);
         default:  res_c = '0;
      endcase
   end

   assign md_bus.alu_res  = res_c;
   assign md_bus.zero     = (res_c == '0);
   assign md_bus.overflow = ovf_c & md_bus.ovf_en;

   md_engine #(.W(W)) u_eng (
      .clk (clk),
      .rst (reset),
      .bus (md_bus)
   );

   assign alu_res  = md_bus.alu_res;
   assign zero     = md_bus.zero;
   assign overflow = md_bus.overflow;
   assign busy     = md_bus.busy;
   assign hi       = md_bus.hi;
   assign lo       = md_bus.lo;

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: ALU vectors, MD results through an expected queue, abort on reset.
// DIV expectations follow ALU_MD_DIV_EN the same way the design does.
module tb_alu_md;
   import alu_md_pkg::*;

   localparam int W = 32;

   logic clk;
   logic reset;

   alu_md_if #(.W(W)) bus ();

   int n_asserts = 0;
   int n_fail    = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] model_hi;
   logic [W-1:0] model_lo;

   alu_md #(.W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (bus.a),
      .b        (bus.b),
      .alu_op   (bus.alu_op),
      .ovf_en   (bus.ovf_en),
      .alu_res  (bus.alu_res),
      .zero     (bus.zero),
      .overflow (bus.overflow),
      .md_start (bus.md_start),
      .md_op    (bus.md_op),
      .busy     (bus.busy),
      .hi       (bus.hi),
      .lo       (bus.lo)
   );

   assign bus.md_state = dut.md_bus.md_state;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before timeout");
      $fatal(1, "bench timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic drive_idle();
      bus.a        = '0;
      bus.b        = '0;
      bus.alu_op   = ALU_ADD;
      bus.ovf_en   = 1'b0;
      bus.md_start = 1'b0;
      bus.md_op    = MD_NONE;
   endtask

   task automatic alu_vec(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic ovf_en, input logic [W-1:0] exp_res,
                          input logic exp_zero, input logic exp_ovf);
      @(negedge clk);
      bus.alu_op = op;
      bus.a      = a;
      bus.b      = b;
      bus.ovf_en = ovf_en;
      #1;
      check({tag, "_res"}, 64'(bus.alu_res), 64'(exp_res));
      check({tag, "_zero"}, 64'(bus.zero), 64'(exp_zero));
      check({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
   endtask

   // Presents md_start for one rising edge; returns on the following falling edge.
   task automatic md_issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      bus.md_op    = op;
      bus.a        = a;
      bus.b        = b;
      bus.md_start = 1'b1;
      @(negedge clk);
      bus.md_start = 1'b0;
      bus.md_op    = MD_NONE;
   endtask

   task automatic expect_md(input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
      exp_q.push_back(e_hi);
      exp_q.push_back(e_lo);
   endtask

   // scoreboard: count busy cycles, then compare HI/LO to the queued expectation
   task automatic wait_md(input string tag, input int exp_busy);
      int n;
      logic [W-1:0] e_hi, e_lo;
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
      if (exp_q.size() >= 2) begin
         e_hi = exp_q.pop_front();
         e_lo = exp_q.pop_front();
         check({tag, "_hi"}, 64'(bus.hi), 64'(e_hi));
         check({tag, "_lo"}, 64'(bus.lo), 64'(e_lo));
         model_hi = e_hi;
         model_lo = e_lo;
      end else begin
         check({tag, "_queue"}, 64'(exp_q.size()), 64'd2);
      end
   endtask

   initial begin
      model_hi = '0;
      model_lo = '0;
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_state", 64'(bus.md_state), 64'(ST_IDLE));
      reset = 1'b0;

      // ALU vectors
      alu_vec("add_ovf_on", ALU_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h80000000, 1'b0, 1'b1);
      alu_vec("add_ovf_off", ALU_ADD, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b0);
      alu_vec("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h0, 1'b1, 1'b0);
      alu_vec("slt", ALU_SLT, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h1, 1'b0, 1'b0);
      alu_vec("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
      alu_vec("sub_zero", ALU_SUB, 32'h5, 32'h5, 1'b1, 32'h0, 1'b1, 1'b0);
      alu_vec("sub_ovf", ALU_SUB, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
      alu_vec("or", ALU_OR, 32'h7FFFFFFF, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0);
      alu_vec("and", ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'h0F000F00, 1'b0, 1'b0);
      alu_vec("xor", ALU_XOR, 32'hFFFF0000, 32'h0FF00FF0, 1'b0, 32'hF00F0FF0, 1'b0, 1'b0);
      alu_vec("nor", ALU_NOR, 32'h0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      drive_idle();

      // multiply
      expect_md(32'hFFFFFFFF, 32'hFFFFFFEB);
      md_issue(MD_MULT, 32'hFFFFFFFD, 32'h7);
      check("mult_state_run", 64'(bus.md_state), 64'(ST_RUN));
      check("mult_hold_lo", 64'(bus.lo), 64'(model_lo));
      wait_md("mult_m3_7", 33);
      expect_md(32'h1, 32'hFFFFFFFE);
      md_issue(MD_MULTU, 32'hFFFFFFFF, 32'h2);
      wait_md("multu_max_2", 33);
      expect_md(32'h1, 32'h23456780);
      md_issue(MD_MULT, 32'h12345678, 32'h10);
      wait_md("mult_shift", 33);

      // divide
`ifdef ALU_MD_DIV_EN
      expect_md(32'hFFFFFFFF, 32'hFFFFFFFD);
      md_issue(MD_DIV, 32'hFFFFFFF9, 32'h2);
      wait_md("div_m7_2", 33);
      expect_md(32'h0000000A, 32'hFFFFFFFF);
      md_issue(MD_DIVU, 32'hA, 32'h0);
      wait_md("divu_by0", 33);
      expect_md(32'h0, 32'h80000000);
      md_issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_md("div_minneg", 33);
      expect_md(32'h2, 32'hE);
      md_issue(MD_DIVU, 32'd100, 32'd7);
      wait_md("divu_100_7", 33);
`else
      expect_md(model_hi, model_lo);
      md_issue(MD_DIV, 32'hFFFFFFF9, 32'h2);
      wait_md("div_absent", 0);
      expect_md(model_hi, model_lo);
      md_issue(MD_DIVU, 32'hA, 32'h0);
      wait_md("divu_absent", 0);
`endif

      // moves and no-op codes
      expect_md(model_hi, 32'h1234);
      md_issue(MD_MTLO, 32'h1234, 32'h0);
      wait_md("mtlo", 0);
      expect_md(32'hBEEF, 32'h1234);
      md_issue(MD_MTHI, 32'hBEEF, 32'h0);
      wait_md("mthi", 0);
      expect_md(32'hBEEF, 32'h1234);
      md_issue(MD_NONE, 32'hDEAD, 32'h1);
      wait_md("op_none", 0);
      expect_md(32'hBEEF, 32'h1234);
      md_issue(3'd7, 32'hDEAD, 32'h1);
      wait_md("op_7", 0);

      // second start during RUN must be dropped
      md_issue(MD_MULT, 32'h3, 32'h5);
      repeat (4) @(negedge clk);
      check("run_hold_hi", 64'(bus.hi), 64'(model_hi));
      bus.md_start = 1'b1;
      bus.md_op    = MD_MULTU;
      bus.a        = 32'hFFFFFFFF;
      bus.b        = 32'hFFFFFFFF;
      @(negedge clk);
      drive_idle();
      expect_md(32'h0, 32'hF);
      wait_md("ignore_start", 28);

      // reset mid-iteration
      expect_md(32'h55, 32'hF);
      md_issue(MD_MTHI, 32'h55, 32'h0);
      wait_md("mthi_pre_abort", 0);
`ifdef ALU_MD_DIV_EN
      md_issue(MD_DIV, 32'd100, 32'd7);
`else
      md_issue(MD_MULT, 32'd100, 32'd7);
`endif
      repeat (9) @(negedge clk);
      check("abort_busy_before", 64'(bus.busy), 64'd1);
      check("abort_hi_before", 64'(bus.hi), 64'(model_hi));
      check("abort_lo_before", 64'(bus.lo), 64'(model_lo));
      #2;
      reset = 1'b1;
      #1;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_hi", 64'(bus.hi), 64'd0);
      check("abort_lo", 64'(bus.lo), 64'd0);
      check("abort_state", 64'(bus.md_state), 64'(ST_IDLE));
      model_hi = '0;
      model_lo = '0;
      @(negedge clk);
      reset = 1'b0;
      expect_md(32'h0, 32'd42);
      md_issue(MD_MULT, 32'd6, 32'd7);
      wait_md("mult_after_rst", 33);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
